// File: rtl/hex_monitor_mux.sv
// rtl/hex_monitor_mux.sv - N-channel address-matched decimal seven-segment monitor
// One sequential double-dabble engine is time-shared round-robin across all channels.
module hex_monitor_mux #(
  parameter int NUM_CH     = 2,
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 9,
  parameter int NUM_DIGITS = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NUM_CH*ADDR_W-1:0]     sel_sw,
  input  logic [NUM_CH*ADDR_W-1:0]     dp_addr,
  input  logic [NUM_CH*DATA_W-1:0]     dp_data,
  output logic [NUM_CH*NUM_DIGITS*7-1:0] hex,
  output logic [NUM_CH-1:0]            ovf,
  output logic                         busy
);

  localparam int BCD_W   = NUM_DIGITS * 4;
  localparam int CNT_W   = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam int PTR_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int LIMIT_I = 10 ** NUM_DIGITS - 1;
  localparam logic [DATA_W-1:0] LIMIT = DATA_W'(LIMIT_I);
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t             state;
  logic [PTR_W-1:0]   ptr;
  logic [CNT_W-1:0]   cnt;
  logic [DATA_W-1:0]  shreg;
  logic [BCD_W-1:0]   bcd;
  logic [BCD_W-1:0]   bcd_adj;
  logic               cap_ovf;
  logic [NUM_CH-1:0]  match_q;
  logic [NUM_CH-1:0]  valid;
  logic [BCD_W-1:0]   disp    [NUM_CH];
  logic [ADDR_W-1:0]  sel_ch  [NUM_CH];
  logic [ADDR_W-1:0]  addr_ch [NUM_CH];
  logic [DATA_W-1:0]  data_ch [NUM_CH];
  logic               live_match;

  function automatic logic [6:0] seg7(input logic [3:0] n);
    case (n)
      4'd0:    seg7 = 7'b1000000;
      4'd1:    seg7 = 7'b1111001;
      4'd2:    seg7 = 7'b0100100;
      4'd3:    seg7 = 7'b0110000;
      4'd4:    seg7 = 7'b0011001;
      4'd5:    seg7 = 7'b0010010;
      4'd6:    seg7 = 7'b0000010;
      4'd7:    seg7 = 7'b1111000;
      4'd8:    seg7 = 7'b0000000;
      4'd9:    seg7 = 7'b0010000;
      default: seg7 = SEG_BLANK;
    endcase
  endfunction

  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      sel_ch[c]  = sel_sw[c*ADDR_W +: ADDR_W];
      addr_ch[c] = dp_addr[c*ADDR_W +: ADDR_W];
      data_ch[c] = dp_data[c*DATA_W +: DATA_W];
    end
    live_match = (sel_ch[ptr] == addr_ch[ptr]);
  end

  // Double-dabble correction applied before each shift.
  always_comb begin
    bcd_adj = bcd;
    for (int d = 0; d < NUM_DIGITS; d++) begin
      if (bcd[d*4 +: 4] >= 4'd5)
        bcd_adj[d*4 +: 4] = bcd[d*4 +: 4] + 4'd3;
    end
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      ptr     <= '0;
      cnt     <= '0;
      shreg   <= '0;
      bcd     <= '0;
      cap_ovf <= 1'b0;
      match_q <= '0;
      valid   <= '0;
      ovf     <= '0;
      hex     <= '1;
      for (int c = 0; c < NUM_CH; c++) disp[c] <= '0;
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        match_q[c] <= (sel_ch[c] == addr_ch[c]);
        if (!match_q[c]) begin
          valid[c] <= 1'b0;
          ovf[c]   <= 1'b0;
        end
        for (int d = 0; d < NUM_DIGITS; d++) begin
          if (!match_q[c] || !valid[c])
            hex[(c*NUM_DIGITS+d)*7 +: 7] <= SEG_BLANK;
          else if (ovf[c])
            hex[(c*NUM_DIGITS+d)*7 +: 7] <= SEG_DASH;
          else
            hex[(c*NUM_DIGITS+d)*7 +: 7] <= seg7(disp[c][d*4 +: 4]);
        end
      end

      case (state)
        IDLE: begin
          if (live_match) begin
            shreg   <= data_ch[ptr];
            cap_ovf <= (data_ch[ptr] > LIMIT);
            bcd     <= '0;
            cnt     <= '0;
            state   <= SHIFT;
          end else begin
            ptr <= (ptr == PTR_W'(NUM_CH-1)) ? '0 : ptr + 1'b1;
          end
        end
        SHIFT: begin
          {bcd, shreg} <= {bcd_adj, shreg} << 1;
          if (cnt == CNT_W'(DATA_W-1))
            state <= DONE;
          else
            cnt <= cnt + 1'b1;
        end
        DONE: begin
          // Placed after the mismatch clear so a fresh result wins on this edge.
          if (live_match) begin
            disp[ptr]  <= bcd;
            ovf[ptr]   <= cap_ovf;
            valid[ptr] <= 1'b1;
          end else begin
            valid[ptr] <= 1'b0;
          end
          ptr   <= (ptr == PTR_W'(NUM_CH-1)) ? '0 : ptr + 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
